// File: rtl/ldst_memport_pkg.sv
// Shared widths and FSM state encoding for the load/store data-memory port.
package ldst_memport_pkg;

  localparam int DATA_LEN    = 32;
  localparam int ADDR_LEN    = 32;
  localparam int SPECTAG_LEN = 5;
  localparam int RRF_SEL     = 6;

  typedef enum logic [0:0] {
    LDST_IDLE = 1'b0,
    LDST_READ = 1'b1
  } ldst_state_e;

endpackage

// File: rtl/ldst_memport_if.sv
// Load request/result, store-buffer, speculation and dmem signals of the memory port.
interface ldst_memport_if;
  import ldst_memport_pkg::*;

  logic                   prmiss;
  logic                   prsuccess;
  logic [SPECTAG_LEN-1:0] prtag;
  logic [SPECTAG_LEN-1:0] spectagfix;

  logic                   ld_req;
  logic                   ld_ready;
  logic [ADDR_LEN-1:0]    ld_addr;
  logic [RRF_SEL-1:0]     ld_rrftag;
  logic                   ld_specbit;
  logic [SPECTAG_LEN-1:0] ld_spectag;

  logic [ADDR_LEN-1:0]    sb_ldaddr;
  logic                   sb_hit;
  logic [DATA_LEN-1:0]    sb_lddata;
  logic                   memoccupy_ld;
  logic                   stretire;
  logic [ADDR_LEN-1:0]    retaddr;
  logic [DATA_LEN-1:0]    retdata;

  logic [ADDR_LEN-1:0]    dmem_addr;
  logic [DATA_LEN-1:0]    dmem_wdata;
  logic                   dmem_we;
  logic [DATA_LEN-1:0]    dmem_rdata;

  logic                   ld_res_valid;
  logic [DATA_LEN-1:0]    ld_res_data;
  logic [RRF_SEL-1:0]     ld_res_rrftag;

  modport slave (
    input  prmiss, prsuccess, prtag, spectagfix,
    input  ld_req, ld_addr, ld_rrftag, ld_specbit, ld_spectag,
    input  sb_hit, sb_lddata, stretire, retaddr, retdata, dmem_rdata,
    output ld_ready, sb_ldaddr, memoccupy_ld,
    output dmem_addr, dmem_wdata, dmem_we,
    output ld_res_valid, ld_res_data, ld_res_rrftag
  );

  modport master (
    output prmiss, prsuccess, prtag, spectagfix,
    output ld_req, ld_addr, ld_rrftag, ld_specbit, ld_spectag,
    output sb_hit, sb_lddata, stretire, retaddr, retdata, dmem_rdata,
    input  ld_ready, sb_ldaddr, memoccupy_ld,
    input  dmem_addr, dmem_wdata, dmem_we,
    input  ld_res_valid, ld_res_data, ld_res_rrftag
  );

endinterface

// File: rtl/spec_kill_chk.sv
// Decides whether a speculative entry dies on a mispredict; shared by the speculative queues.
module spec_kill_chk #(
  parameter int SPECTAG_LEN = 5
) (
  input  logic                   specbit,
  input  logic [SPECTAG_LEN-1:0] spectag,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  output logic                   kill
);

  assign kill = specbit & (|(spectagfix & spectag));

endmodule

// File: rtl/ldst_memport.sv
// Single-port dmem controller: arbitrates loads against store retirement, forwards
// store-buffer hits, and returns tagged load results with mispredict squashing.
module ldst_memport
  import ldst_memport_pkg::*;
#(
  parameter int DMEM_LAT = 1,
  parameter int LD_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  ldst_memport_if.slave bus
);

  localparam int LAT_W = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;
  localparam int BST_W = $clog2(LD_BURST + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DMEM_LAT - 1);
  localparam logic [BST_W-1:0] BST_MAX  = BST_W'(LD_BURST);

  ldst_state_e            state_q, state_d;
  logic [LAT_W-1:0]       lat_cnt_q;
  logic [BST_W-1:0]       bst_cnt_q;

  logic [ADDR_LEN-1:0]    cap_addr_q;
  logic [RRF_SEL-1:0]     cap_rrftag_q;
  logic                   cap_specbit_q;
  logic [SPECTAG_LEN-1:0] cap_spectag_q;

  logic                   res_vld_p1;
  logic [DATA_LEN-1:0]    res_data_p1;
  logic [RRF_SEL-1:0]     res_rrftag_p1;
  logic                   res_specbit_p1;
  logic [SPECTAG_LEN-1:0] res_spectag_p1;

  logic force_st, accept, accept_hit, accept_miss, read_last;
  logic cap_kill, res_kill, cap_drop, prs_ld, prs_cap;

  spec_kill_chk #(.SPECTAG_LEN(SPECTAG_LEN)) u_cap_kill (
    .specbit    (cap_specbit_q),
    .spectag    (cap_spectag_q),
    .spectagfix (bus.spectagfix),
    .kill       (cap_kill)
  );

  spec_kill_chk #(.SPECTAG_LEN(SPECTAG_LEN)) u_res_kill (
    .specbit    (res_specbit_p1),
    .spectag    (res_spectag_p1),
    .spectagfix (bus.spectagfix),
    .kill       (res_kill)
  );

  // A resolved-correct branch only counts when no mispredict arrives with it.
  assign prs_ld    = bus.prsuccess & ~bus.prmiss & (bus.ld_spectag == bus.prtag);
  assign prs_cap   = bus.prsuccess & ~bus.prmiss & (cap_spectag_q == bus.prtag);
  assign cap_drop  = bus.prmiss & cap_kill;
  assign read_last = (state_q == LDST_READ) && (lat_cnt_q == LAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LDST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LDST_IDLE: if (accept_miss)           state_d = LDST_READ;
      LDST_READ: if (cap_drop || read_last) state_d = LDST_IDLE;
      default:                              state_d = LDST_IDLE;
    endcase
  end

  always_comb begin
    force_st         = (state_q == LDST_IDLE) && (bst_cnt_q == BST_MAX);
    bus.ld_ready     = (state_q == LDST_IDLE) & ~bus.prmiss & ~force_st;
    accept           = bus.ld_req & bus.ld_ready;
    accept_hit       = accept & bus.sb_hit;
    accept_miss      = accept & ~bus.sb_hit;
    bus.memoccupy_ld = accept_miss | (state_q == LDST_READ);
    bus.sb_ldaddr    = bus.ld_addr;
    bus.dmem_we      = bus.stretire;
    bus.dmem_wdata   = bus.retdata;
    if (bus.stretire) begin
      bus.dmem_addr = bus.retaddr;
    end else if (state_q == LDST_READ) begin
      bus.dmem_addr = cap_addr_q;
    end else begin
      bus.dmem_addr = bus.ld_addr;
    end
    bus.ld_res_valid  = res_vld_p1 & ~(bus.prmiss & res_kill);
    bus.ld_res_data   = res_data_p1;
    bus.ld_res_rrftag = res_rrftag_p1;
  end

  always_ff @(posedge clk) begin
    if (accept_miss) begin
      cap_addr_q    <= bus.ld_addr;
      cap_rrftag_q  <= bus.ld_rrftag;
      cap_spectag_q <= bus.ld_spectag;
    end
    // p1: result register, presented the cycle after the data is known
    if (accept_hit) begin
      res_data_p1    <= bus.sb_lddata;
      res_rrftag_p1  <= bus.ld_rrftag;
      res_spectag_p1 <= bus.ld_spectag;
    end else if (read_last) begin
      res_data_p1    <= bus.dmem_rdata;
      res_rrftag_p1  <= cap_rrftag_q;
      res_spectag_p1 <= cap_spectag_q;
    end
    if (reset) begin
      lat_cnt_q      <= '0;
      bst_cnt_q      <= '0;
      cap_specbit_q  <= 1'b0;
      res_vld_p1     <= 1'b0;
      res_specbit_p1 <= 1'b0;
    end else begin
      res_vld_p1 <= 1'b0;
      if (accept_miss) begin
        lat_cnt_q <= '0;
      end else if (state_q == LDST_READ) begin
        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
      end
      if (accept_miss) begin
        bst_cnt_q <= bst_cnt_q + BST_W'(1);
      end else if (state_q == LDST_IDLE) begin
        bst_cnt_q <= '0;
      end
      if (accept_miss) begin
        cap_specbit_q <= bus.ld_specbit & ~prs_ld;
      end else if (prs_cap) begin
        cap_specbit_q <= 1'b0;
      end
      if (accept_hit) begin
        res_vld_p1     <= 1'b1;
        res_specbit_p1 <= bus.ld_specbit & ~prs_ld;
      end else if (read_last && !cap_drop) begin
        res_vld_p1     <= 1'b1;
        res_specbit_p1 <= cap_specbit_q & ~prs_cap;
      end
    end
  end

  // The store buffer must hold off retirement while dmem is reserved for a load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.stretire && bus.memoccupy_ld));
    end
  end

endmodule

// File: tb/tb_ldst_memport.sv
// Bench for ldst_memport: directed scenarios plus randomized traffic against a
// transaction-level model of loads, forwarding, arbitration and squashing.
module tb_ldst_memport;
  import ldst_memport_pkg::*;

  localparam int DMEM_LAT = 1;
  localparam int LD_BURST = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ldst_memport_if bus();

  ldst_memport #(.DMEM_LAT(DMEM_LAT), .LD_BURST(LD_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [RRF_SEL-1:0]     tag;
    logic [DATA_LEN-1:0]    data;
    logic                   sb;
    logic [SPECTAG_LEN-1:0] st;
    int                     due;
  } ent_t;

  ent_t pend[$];
  int   cyc = 0;
  int   m_burst = 0;
  int   m_last = 0;
  bit   m_inflight = 1'b0;
  bit   chk_en = 1'b0;
  logic [ADDR_LEN-1:0] m_addr;
  logic [DATA_LEN-1:0] mem [0:63];
  logic [ADDR_LEN-1:0] apipe [DMEM_LAT];
  int   tests = 0;
  int   fails = 0;

  // dmem: read data appears DMEM_LAT cycles after the address
  always @(posedge clk) begin
    apipe[0] <= bus.dmem_addr;
    for (int i = 1; i < DMEM_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.dmem_rdata = mem[apipe[DMEM_LAT-1][7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit killed(input logic sb, input logic [SPECTAG_LEN-1:0] st);
    return bus.prmiss && sb && ((st & bus.spectagfix) != '0);
  endfunction

  // Advance the model by one clock using the inputs held during the cycle.
  task automatic model_update();
    bit in_read, frc, rdy, acc, miss, found;
    logic nsb;
    if (reset) begin
      pend.delete();
      m_inflight = 1'b0;
      m_burst = 0;
    end else begin
      in_read = m_inflight;
      frc  = !in_read && (m_burst == LD_BURST);
      rdy  = !in_read && !bus.prmiss && !frc;
      acc  = bus.ld_req && rdy;
      miss = acc && !bus.sb_hit;
      if (bus.prmiss) begin
        for (int i = pend.size() - 1; i >= 0; i--)
          if (killed(pend[i].sb, pend[i].st)) pend.delete(i);
        found = 1'b0;
        foreach (pend[i]) if (pend[i].due == m_last + 1) found = 1'b1;
        if (m_inflight && !found) m_inflight = 1'b0;
      end else if (bus.prsuccess) begin
        foreach (pend[i]) if (pend[i].st == bus.prtag) pend[i].sb = 1'b0;
      end
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due <= cyc) pend.delete(i);
      if (m_inflight && cyc == m_last) m_inflight = 1'b0;
      if (miss) m_burst++;
      else if (!in_read) m_burst = 0;
      if (acc) begin
        nsb = bus.ld_specbit && !(bus.prsuccess && bus.ld_spectag == bus.prtag);
        pend.push_back('{bus.ld_rrftag, bus.sb_hit ? bus.sb_lddata : mem[bus.ld_addr[7:2]],
                         nsb, bus.ld_spectag, bus.sb_hit ? cyc + 1 : cyc + DMEM_LAT + 1});
        if (miss) begin
          m_inflight = 1'b1;
          m_last = cyc + DMEM_LAT;
          m_addr = bus.ld_addr;
        end
      end
      if (bus.stretire) mem[bus.retaddr[7:2]] = bus.retdata;
    end
    cyc++;
  endtask

  bit   c_read, c_frc, c_rdy, c_occ, c_ev;
  ent_t c_e;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      c_read = m_inflight;
      c_frc  = !c_read && (m_burst == LD_BURST);
      c_rdy  = !c_read && !bus.prmiss && !c_frc;
      c_occ  = c_read || (c_rdy && bus.ld_req && !bus.sb_hit);
      c_ev   = 1'b0;
      foreach (pend[i])
        if (pend[i].due == cyc && !killed(pend[i].sb, pend[i].st)) begin
          c_ev = 1'b1;
          c_e  = pend[i];
        end
      chk("m_ld_ready", 32'(bus.ld_ready), 32'(c_rdy));
      chk("m_memoccupy", 32'(bus.memoccupy_ld), 32'(c_occ));
      chk("m_dmem_we", 32'(bus.dmem_we), 32'(bus.stretire));
      chk("m_sb_ldaddr", bus.sb_ldaddr, bus.ld_addr);
      if (bus.stretire) begin
        chk("m_st_addr", bus.dmem_addr, bus.retaddr);
        chk("m_st_wdata", bus.dmem_wdata, bus.retdata);
      end else if (c_read) begin
        chk("m_rd_addr", bus.dmem_addr, m_addr);
      end else if (c_occ) begin
        chk("m_issue_addr", bus.dmem_addr, bus.ld_addr);
      end
      chk("m_res_valid", 32'(bus.ld_res_valid), 32'(c_ev));
      if (c_ev) begin
        chk("m_res_data", bus.ld_res_data, c_e.data);
        chk("m_res_tag", 32'(bus.ld_res_rrftag), 32'(c_e.tag));
      end
    end
  end

  task automatic idle_inputs();
    bus.prmiss = 1'b0;  bus.prsuccess = 1'b0; bus.prtag = '0; bus.spectagfix = '0;
    bus.ld_req = 1'b0;  bus.ld_addr = '0;     bus.ld_rrftag = '0;
    bus.ld_specbit = 1'b0; bus.ld_spectag = '0;
    bus.sb_hit = 1'b0;  bus.sb_lddata = '0;
    bus.stretire = 1'b0; bus.retaddr = '0;    bus.retdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // The store buffer only retires when dmem is not reserved for a load.
  task automatic store_gate(input bit want);
    #1 bus.stretire = want && !bus.memoccupy_ld;
    #1;
  endtask

  task automatic miss_load(input logic [31:0] a, input logic [5:0] t, input logic sb,
                           input logic [4:0] st);
    idle_inputs();
    bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_rrftag = t;
    bus.ld_specbit = sb; bus.ld_spectag = st;
  endtask

  logic [31:0] prev;
  bit er;

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[16] = 32'h0000DEAD;
    mem[9]  = 32'hC0FFEE01;
    mem[10] = 32'hBEEF0010;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    store_gate(1'b0);
    chk("rst_res_valid", 32'(bus.ld_res_valid), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_memoccupy", 32'(bus.memoccupy_ld), 32'd0);
    tick();

    // dmem miss with one-cycle latency
    miss_load(32'h40, 6'h2A, 1'b0, 5'b0); store_gate(1'b0);
    chk("t1_occ_c0", 32'(bus.memoccupy_ld), 32'd1);
    chk("t1_addr_c0", bus.dmem_addr, 32'h40);
    tick(); idle_inputs(); store_gate(1'b0);
    chk("t1_occ_c1", 32'(bus.memoccupy_ld), 32'd1);
    chk("t1_ready_c1", 32'(bus.ld_ready), 32'd0);
    tick(); idle_inputs(); store_gate(1'b0);
    chk("t1_valid", 32'(bus.ld_res_valid), 32'd1);
    chk("t1_data", bus.ld_res_data, 32'h0000DEAD);
    chk("t1_tag", 32'(bus.ld_res_rrftag), 32'h2A);
    chk("t1_occ_c2", 32'(bus.memoccupy_ld), 32'd0);
    tick();

    // store-buffer hits, back to back
    miss_load(32'h80, 6'h05, 1'b0, 5'b0);
    bus.sb_hit = 1'b1; bus.sb_lddata = 32'h1234; store_gate(1'b0);
    chk("t2_occ", 32'(bus.memoccupy_ld), 32'd0);
    chk("t2_we", 32'(bus.dmem_we), 32'd0);
    tick();
    prev = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      miss_load(32'h84 + 32'(4 * i), 6'(8 + i), 1'b0, 5'b0);
      bus.sb_hit = 1'b1; bus.sb_lddata = 32'hA000 + 32'(i); store_gate(1'b0);
      chk("t2_ready", 32'(bus.ld_ready), 32'd1);
      chk("t2_valid", 32'(bus.ld_res_valid), 32'd1);
      chk("t2_data", bus.ld_res_data, prev);
      prev = 32'hA000 + 32'(i);
      tick();
    end
    idle_inputs(); store_gate(1'b0);
    chk("t2_last_valid", 32'(bus.ld_res_valid), 32'd1);
    chk("t2_last_data", bus.ld_res_data, 32'hA003);
    tick();

    // store retire, then a dmem load that blocks the next retire
    idle_inputs(); bus.retaddr = 32'h10; bus.retdata = 32'h55; store_gate(1'b1);
    chk("t3_we", 32'(bus.dmem_we), 32'd1);
    chk("t3_addr", bus.dmem_addr, 32'h10);
    chk("t3_wdata", bus.dmem_wdata, 32'h55);
    tick();
    miss_load(32'h10, 6'h03, 1'b0, 5'b0);
    bus.retaddr = 32'h14; bus.retdata = 32'h66; store_gate(1'b1);
    chk("t3_blk_occ", 32'(bus.memoccupy_ld), 32'd1);
    chk("t3_blk_we", 32'(bus.dmem_we), 32'd0);
    tick(); idle_inputs(); store_gate(1'b0);
    tick(); idle_inputs(); store_gate(1'b0);
    chk("t3_rd_valid", 32'(bus.ld_res_valid), 32'd1);
    chk("t3_rd_data", bus.ld_res_data, 32'h55);
    tick();

    // continuous misses: one forced store slot after LD_BURST grants
    for (int k = 0; k < 18; k++) begin
      miss_load(32'((k * 4) & 8'hFC), 6'(k), 1'b0, 5'b0);
      bus.retaddr = 32'hF0; bus.retdata = 32'h77 + 32'(k); store_gate(1'b1);
      er = (k < 16) ? (k % 2 == 0) : (k == 17);
      chk("t4_ready", 32'(bus.ld_ready), 32'(er));
      chk("t4_occ", 32'(bus.memoccupy_ld), 32'(k != 16));
      chk("t4_we", 32'(bus.dmem_we), 32'(k == 16));
      tick();
    end
    idle_inputs(); store_gate(1'b0); tick();
    idle_inputs(); store_gate(1'b0); tick();

    // mispredict during READ: killed, then not killed
    for (int rep = 0; rep < 2; rep++) begin
      miss_load(32'h24, 6'h11, 1'b1, 5'b00100); store_gate(1'b0);
      tick();
      idle_inputs(); bus.prmiss = 1'b1;
      bus.spectagfix = (rep == 1) ? 5'b01000 : 5'b00110; store_gate(1'b0);
      chk("t5_occ", 32'(bus.memoccupy_ld), 32'd1);
      tick(); idle_inputs(); store_gate(1'b0);
      chk("t5_valid", 32'(bus.ld_res_valid), 32'(rep == 1));
      chk("t5_ready", 32'(bus.ld_ready), 32'd1);
      if (rep == 1) chk("t5_data", bus.ld_res_data, 32'hC0FFEE01);
      tick();
    end

    // prsuccess on the capture cycle protects the load from a later mispredict
    miss_load(32'h28, 6'h22, 1'b1, 5'b00010);
    bus.prsuccess = 1'b1; bus.prtag = 5'b00010; store_gate(1'b0);
    tick(); idle_inputs(); bus.prmiss = 1'b1; bus.spectagfix = 5'b00010; store_gate(1'b0);
    tick(); idle_inputs(); store_gate(1'b0);
    chk("t6_valid", 32'(bus.ld_res_valid), 32'd1);
    chk("t6_data", bus.ld_res_data, 32'hBEEF0010);
    chk("t6_tag", 32'(bus.ld_res_rrftag), 32'h22);
    tick();

    // reset while reading abandons the load
    miss_load(32'h2C, 6'h33, 1'b0, 5'b0); store_gate(1'b0);
    tick(); reset = 1'b1; idle_inputs();
    tick(); reset = 1'b0; store_gate(1'b0);
    chk("rst_mid_valid", 32'(bus.ld_res_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.ld_ready), 32'd1);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      idle_inputs();
      if (reset) begin
        store_gate(1'b0);
      end else begin
        bus.prmiss     = ($urandom_range(0, 11) == 0);
        bus.prsuccess  = ($urandom_range(0, 7) == 0);
        bus.prtag      = 5'(1 << $urandom_range(0, 4));
        bus.spectagfix = 5'($urandom);
        bus.ld_req     = ($urandom_range(0, 9) < 7);
        bus.ld_addr    = {24'h0, 6'($urandom), 2'b00};
        bus.ld_rrftag  = 6'($urandom);
        bus.ld_specbit = 1'($urandom_range(0, 1));
        bus.ld_spectag = 5'(1 << $urandom_range(0, 4));
        bus.sb_hit     = ($urandom_range(0, 2) == 0);
        bus.sb_lddata  = $urandom;
        bus.retaddr    = {24'h0, 6'($urandom), 2'b00};
        bus.retdata    = $urandom;
        store_gate($urandom_range(0, 2) == 0);
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs(); store_gate(1'b0); tick();
    idle_inputs(); store_gate(1'b0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
